// File: rtl/tile_in_buffer_if.sv
// Link-side bundle for tile_in_buffer: incoming words, pop requests, credits and status.
// Channel i occupies slice [i*(DATA_W+1) +: DATA_W+1] of the word buses, MSB = valid.
interface tile_in_buffer_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DEPTH  = 2
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                           conf_en;
    logic [NUM_CH*(DATA_W+1)-1:0]   d_in;
    logic [NUM_CH-1:0]              rd_en;
    logic [NUM_CH-1:0]              c_out;
    logic [NUM_CH*(DATA_W+1)-1:0]   d_out;
    logic [NUM_CH*CNT_W-1:0]        occ;
    logic [NUM_CH-1:0]              ovf;

    modport master (
        output conf_en, d_in, rd_en,
        input  c_out, d_out, occ, ovf
    );

    modport slave (
        input  conf_en, d_in, rd_en,
        output c_out, d_out, occ, ovf
    );
endinterface

// File: rtl/tile_in_buffer.sv
// Credit-flow input buffer bank: NUM_CH independent DEPTH-entry FIFOs with sticky overflow,
// one credit pulse per pop and a synchronous flush on conf_en.
module tile_in_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DEPTH  = 2
) (
    input logic             clk,
    input logic             rst,
    tile_in_buffer_if.slave bus
);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned WORD_W = DATA_W + 1;

    // Explicit compare so non-power-of-two depths wrap correctly.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    logic [WORD_W-1:0] d_out_ch [NUM_CH];
    logic [CNT_W-1:0]  occ_ch   [NUM_CH];
    logic [NUM_CH-1:0] credit_vec;
    logic [NUM_CH-1:0] ovf_vec;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DATA_W-1:0] mem_q [DEPTH];
        logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
        logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
        logic [CNT_W-1:0]  occ_q, occ_d;
        logic              ovf_q, ovf_d;
        logic              credit_q, credit_d;
        logic [WORD_W-1:0] word_in;
        logic              push, pop, full, wr_en;

        assign word_in = bus.d_in[i*WORD_W +: WORD_W];
        assign push    = word_in[DATA_W];
        assign full    = (occ_q == CNT_W'(DEPTH));
        assign pop     = bus.rd_en[i] && (occ_q != '0);
        // A push into a full FIFO is still accepted when the head leaves on the same edge.
        assign wr_en   = !bus.conf_en && push && (!full || pop);

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            occ_d    = occ_q;
            ovf_d    = ovf_q;
            credit_d = 1'b0;
            if (bus.conf_en) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                occ_d    = '0;
                ovf_d    = 1'b0;
            end else begin
                credit_d = pop;
                if (wr_en) begin
                    wr_ptr_d = next_ptr(wr_ptr_q);
                end
                if (pop) begin
                    rd_ptr_d = next_ptr(rd_ptr_q);
                end
                if (push && full && !pop) begin
                    ovf_d = 1'b1;
                end
                if (wr_en && !pop) begin
                    occ_d = occ_q + 1'b1;
                end else if (pop && !wr_en) begin
                    occ_d = occ_q - 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                occ_q    <= '0;
                ovf_q    <= 1'b0;
                credit_q <= 1'b0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                occ_q    <= occ_d;
                ovf_q    <= ovf_d;
                credit_q <= credit_d;
            end
        end

        // Storage needs no reset; the payload is masked whenever the FIFO is empty.
        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= word_in[DATA_W-1:0];
            end
        end

        assign d_out_ch[i]   = (occ_q != '0) ? {1'b1, mem_q[rd_ptr_q]} : '0;
        assign occ_ch[i]     = occ_q;
        assign credit_vec[i] = credit_q;
        assign ovf_vec[i]    = ovf_q;
    end

    always_comb begin
        bus.d_out = '0;
        bus.occ   = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            bus.d_out[k*WORD_W +: WORD_W] = d_out_ch[k];
            bus.occ[k*CNT_W +: CNT_W]     = occ_ch[k];
        end
    end

    assign bus.c_out = credit_vec;
    assign bus.ovf   = ovf_vec;
endmodule

// File: tb/tb_tile_in_buffer.sv
// Bench for tile_in_buffer: DEPTH=3 and DEPTH=1 instances share stimulus and are checked
// every cycle against a queue-based model, plus directed scenarios with literal expectations.
module tb_tile_in_buffer;
    localparam int unsigned DW  = 32;
    localparam int unsigned NC  = 4;
    localparam int unsigned WW  = DW + 1;
    localparam int unsigned CW3 = $clog2(3 + 1);
    localparam int unsigned CW1 = $clog2(1 + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             conf_en;
    logic [NC*WW-1:0] din;
    logic [NC-1:0]    rd_en;

    int n_err   = 0;
    int n_check = 0;

    tile_in_buffer_if #(.DATA_W(DW), .NUM_CH(NC), .DEPTH(3)) bus3 ();
    tile_in_buffer_if #(.DATA_W(DW), .NUM_CH(NC), .DEPTH(1)) bus1 ();

    assign bus3.conf_en = conf_en;
    assign bus3.d_in    = din;
    assign bus3.rd_en   = rd_en;
    assign bus1.conf_en = conf_en;
    assign bus1.d_in    = din;
    assign bus1.rd_en   = rd_en;

    tile_in_buffer #(.DATA_W(DW), .NUM_CH(NC), .DEPTH(3)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    tile_in_buffer #(.DATA_W(DW), .NUM_CH(NC), .DEPTH(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    // Reference model: one queue per instance and channel.
    logic [DW-1:0] m_q     [2][NC][$];
    bit            m_ovf   [2][NC];
    bit            m_cred  [2][NC];
    int            m_depth [2] = '{3, 1};

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                for (int c = 0; c < NC; c++) begin
                    m_q[k][c].delete();
                    m_ovf[k][c]  = 0;
                    m_cred[k][c] = 0;
                end
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                for (int c = 0; c < NC; c++) begin
                    bit            push;
                    bit            pop;
                    int            sz;
                    logic [DW-1:0] data;
                    push = din[c*WW + DW];
                    data = din[c*WW +: DW];
                    sz   = m_q[k][c].size();
                    if (conf_en) begin
                        m_q[k][c].delete();
                        m_ovf[k][c]  = 0;
                        m_cred[k][c] = 0;
                    end else begin
                        pop          = rd_en[c] && (sz > 0);
                        m_cred[k][c] = pop;
                        if (pop) void'(m_q[k][c].pop_front());
                        if (push) begin
                            if (sz < m_depth[k] || pop) m_q[k][c].push_back(data);
                            else m_ovf[k][c] = 1;
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int ch, input logic [63:0] act,
                         input logic [63:0] exp);
        n_check++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s ch%0d: got %h want %h at %0t", name, ch, act, exp, $time);
        end
    endtask

    function automatic logic [WW-1:0] m_word(input int k, input int c);
        if (m_q[k][c].size() == 0) return '0;
        return {1'b1, m_q[k][c][0]};
    endfunction

    always @(negedge clk) begin
        for (int c = 0; c < NC; c++) begin
            check("d3_dout", c, 64'(bus3.d_out[c*WW +: WW]), 64'(m_word(0, c)));
            check("d3_occ",  c, 64'(bus3.occ[c*CW3 +: CW3]), 64'(m_q[0][c].size()));
            check("d3_cout", c, 64'(bus3.c_out[c]), 64'(m_cred[0][c]));
            check("d3_ovf",  c, 64'(bus3.ovf[c]), 64'(m_ovf[0][c]));
            check("d1_dout", c, 64'(bus1.d_out[c*WW +: WW]), 64'(m_word(1, c)));
            check("d1_occ",  c, 64'(bus1.occ[c*CW1 +: CW1]), 64'(m_q[1][c].size()));
            check("d1_cout", c, 64'(bus1.c_out[c]), 64'(m_cred[1][c]));
            check("d1_ovf",  c, 64'(bus1.ovf[c]), 64'(m_ovf[1][c]));
        end
    end

    function automatic logic [WW-1:0] dout3(input int c);
        return bus3.d_out[c*WW +: WW];
    endfunction

    function automatic logic [CW3-1:0] occ3(input int c);
        return bus3.occ[c*CW3 +: CW3];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int c, input logic [DW-1:0] data);
        din = '0;
        din[c*WW +: WW] = {1'b1, data};
    endtask

    task automatic push_seq(input int c, input logic [DW-1:0] data);
        put(c, data);
        step();
        din = '0;
    endtask

    initial begin
        rst     = 1'b0;
        conf_en = 1'b0;
        rd_en   = '1;
        din     = '0;
        for (int c = 0; c < NC; c++) din[c*WW +: WW] = {1'b1, 32'(c + 1)};

        // Reset held with traffic present
        repeat (3) step();
        for (int c = 0; c < NC; c++) begin
            check("rst_dout", c, 64'(dout3(c)), 64'd0);
            check("rst_occ",  c, 64'(occ3(c)), 64'd0);
        end
        check("rst_cout", 0, 64'(bus3.c_out), 64'd0);
        check("rst_ovf",  0, 64'(bus3.ovf), 64'd0);

        rst   = 1'b1;
        rd_en = '0;
        push_seq(0, 32'h11);
        check("first_push", 0, 64'(dout3(0)), {31'd0, 1'b1, 32'h11});
        check("first_occ",  0, 64'(occ3(0)), 64'd1);

        // Order and wrap on ch1
        push_seq(1, 32'hA);
        push_seq(1, 32'hB);
        push_seq(1, 32'hC);
        check("fill_occ",  1, 64'(occ3(1)), 64'd3);
        check("fill_head", 1, 64'(dout3(1)), {31'd0, 1'b1, 32'hA});
        rd_en = 4'b0010;
        step();
        check("pop1_head", 1, 64'(dout3(1)), {31'd0, 1'b1, 32'hB});
        check("pop1_cred", 1, 64'(bus3.c_out[1]), 64'd1);
        step();
        check("pop2_head", 1, 64'(dout3(1)), {31'd0, 1'b1, 32'hC});
        check("pop2_cred", 1, 64'(bus3.c_out[1]), 64'd1);
        rd_en = '0;
        step();
        check("cred_end", 1, 64'(bus3.c_out[1]), 64'd0);
        push_seq(1, 32'hD);
        push_seq(1, 32'hE);
        check("wrap_occ", 1, 64'(occ3(1)), 64'd3);
        rd_en = 4'b0010;
        check("drain_c", 1, 64'(dout3(1)), {31'd0, 1'b1, 32'hC});
        step();
        check("drain_d", 1, 64'(dout3(1)), {31'd0, 1'b1, 32'hD});
        step();
        check("drain_e", 1, 64'(dout3(1)), {31'd0, 1'b1, 32'hE});
        step();
        check("drain_empty", 1, 64'(dout3(1)), 64'd0);
        rd_en = '0;

        // Overflow on ch2
        push_seq(2, 32'd1);
        push_seq(2, 32'd2);
        push_seq(2, 32'd3);
        push_seq(2, 32'd4);
        check("ovf_set",  2, 64'(bus3.ovf[2]), 64'd1);
        check("ovf_head", 2, 64'(dout3(2)), {31'd0, 1'b1, 32'd1});
        check("ovf_occ",  2, 64'(occ3(2)), 64'd3);
        rd_en = 4'b0100;
        step();
        check("ovf_pop2", 2, 64'(dout3(2)), {31'd0, 1'b1, 32'd2});
        step();
        check("ovf_pop3", 2, 64'(dout3(2)), {31'd0, 1'b1, 32'd3});
        step();
        check("ovf_sticky", 2, 64'(bus3.ovf[2]), 64'd1);
        rd_en = '0;

        // Push and pop together while full on ch3
        push_seq(3, 32'd5);
        push_seq(3, 32'd6);
        push_seq(3, 32'd8);
        put(3, 32'd7);
        rd_en = 4'b1000;
        step();
        din   = '0;
        rd_en = '0;
        check("pp_ovf",  3, 64'(bus3.ovf[3]), 64'd0);
        check("pp_occ",  3, 64'(occ3(3)), 64'd3);
        check("pp_head", 3, 64'(dout3(3)), {31'd0, 1'b1, 32'd6});
        check("pp_cred", 3, 64'(bus3.c_out[3]), 64'd1);
        step();
        check("pp_cred_once", 3, 64'(bus3.c_out[3]), 64'd0);
        rd_en = 4'b1000;
        step();
        check("pp_8", 3, 64'(dout3(3)), {31'd0, 1'b1, 32'd8});
        step();
        check("pp_7", 3, 64'(dout3(3)), {31'd0, 1'b1, 32'd7});
        step();
        rd_en = '0;

        // Flush on conf_en
        push_seq(0, 32'h21);
        push_seq(0, 32'h22);
        push_seq(0, 32'h23);
        check("fl_pre_ovf", 0, 64'(bus3.ovf[0]), 64'd1);
        conf_en = 1'b1;
        put(0, 32'h99);
        step();
        conf_en = 1'b0;
        din     = '0;
        check("fl_occ",  0, 64'(occ3(0)), 64'd0);
        check("fl_dout", 0, 64'(dout3(0)), 64'd0);
        check("fl_ovf",  0, 64'(bus3.ovf[0]), 64'd0);
        check("fl_cout", 0, 64'(bus3.c_out), 64'd0);
        step();
        check("fl_nostore", 0, 64'(occ3(0)), 64'd0);
        check("fl_nocred",  0, 64'(bus3.c_out), 64'd0);

        // Pop on empty, then asynchronous reset between edges
        rd_en = 4'b0010;
        step();
        rd_en = '0;
        check("empty_pop", 1, 64'(bus3.c_out[1]), 64'd0);
        push_seq(2, 32'h55);
        push_seq(2, 32'h56);
        #1 rst = 1'b0;
        #1;
        for (int c = 0; c < NC; c++) begin
            check("arst_dout", c, 64'(dout3(c)), 64'd0);
            check("arst_occ",  c, 64'(occ3(c)), 64'd0);
        end
        check("arst_ovf", 0, 64'(bus3.ovf), 64'd0);
        step();
        rst = 1'b1;

        // Randomised traffic
        repeat (3000) begin
            for (int c = 0; c < NC; c++) begin
                din[c*WW +: WW] = {1'($urandom_range(0, 1)), 32'($urandom)};
            end
            rd_en   = 4'($urandom);
            conf_en = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b0;
                #1 rst = 1'b1;
            end
            step();
        end
        din     = '0;
        rd_en   = '0;
        conf_en = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_check);
        $finish;
    end
endmodule

// File: doc/tile_in_buffer.md
Name: tile_in_buffer

Overview:
- Parametrised credit-flow input buffer bank for the next-generation tile. It sits between the inter-tile data links and the tile's switch/functional-unit input muxes.
- Provides NUM_CH independent channels, each a DEPTH-entry FIFO, replacing the single-slot, fixed-width links.
- Each pop returns one credit upstream. Overflow is detected and reported sticky, and conf_en flushes all channels for reconfiguration.

Parameters:
- DATA_W, 32, payload width. The link word is DATA_W+1 bits with MSB = valid, same as the existing PATH_WIDTH:0 convention.
- NUM_CH, 4, number of independent channels (N/E/S/W default).
- DEPTH, 2, entries per channel FIFO; must be ≥1. Upstream credit counters initialise to DEPTH.
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived).

Ports:
- clk, input, 1, single clock, rising edge.
- rst, input, 1, asynchronous active-low reset.
- conf_en, input, 1, configuration mode: synchronous flush, writes blocked.
- d_in, input, NUM_CH*(DATA_W+1), incoming link words. Channel i occupies bits [i*(DATA_W+1) +: DATA_W+1], MSB = valid.
- c_out, output, NUM_CH, credit return to upstream; one-cycle pulse per freed entry.
- rd_en, input, NUM_CH, consumer pop request per channel.
- d_out, output, NUM_CH*(DATA_W+1), head-of-FIFO word per channel, MSB = valid (non-empty).
- occ, output, NUM_CH*CNT_W, per-channel occupancy.
- ovf, output, NUM_CH, sticky overflow flag per channel.

Behaviour:
- Reset (rst=0, async): all FIFOs empty, pointers 0, occ=0, c_out=0, ovf=0, d_out=0. Outputs are safe during reset.
- Per channel, per rising edge, when conf_en=0:
  - push = d_in valid bit; pop = rd_en & (occ!=0).
  - push & occ<DEPTH: write payload at wr_ptr; wr_ptr wraps DEPTH-1 → 0.
  - push & occ==DEPTH & pop: accepted. Occupancy is unchanged, no overflow.
  - push & occ==DEPTH & !pop: word dropped, ovf[i] set. ovf[i] clears only on reset or conf_en.
  - pop: rd_ptr advances with wrap. c_out[i]=1 on the next cycle, for exactly one cycle per pop.
  - rd_en with occ==0: ignored; no credit and no pointer move.
  - occ updates: +1 on push-only, -1 on pop-only, unchanged on both or neither.
- d_out:
  - Combinational from the head entry.
  - valid = (occ!=0); payload = head data when valid, else all zeros.
  - Write-to-visible latency is 1 cycle: a word pushed at edge t appears at d_out after t.
  - No fall-through; an empty FIFO never shows the same-cycle d_in.
- Credit latency:
  - Pop at edge t gives c_out high for cycle t→t+1.
  - Upstream counter starts at DEPTH, so back-to-back pops give back-to-back credit pulses.
- conf_en=1 (synchronous, takes priority over push/pop):
  - At each edge: all pointers and occ reset to 0, ovf cleared, c_out forced 0, d_in ignored.
  - Upstream also resets its counter to DEPTH on conf_en (system rule), so flushed entries generate no credits.
- Channels are fully independent; no cross-channel arbitration.
- DEPTH=1 must work: a single entry, pointers constant 0.
- Non-power-of-two DEPTH must wrap correctly (explicit compare, not natural overflow).

Test Plan:
1. Reset/release: hold rst=0, drive d_in valid and rd_en → d_out=0, c_out=0, occ=0, ovf=0. Release, then push 0x11 on ch0 → after 1 edge, d_out ch0 = {1,0x11}, occ0=1.
2. FIFO order and wrap (DEPTH=3):
   - Push 0xA, 0xB, 0xC on ch1 → occ1=3.
   - Pop ×2 → d_out shows 0xC, with two consecutive c_out[1] pulses each lagging its pop by 1 cycle.
   - Push 0xD, 0xE → wrap verified; drain order is C, D, E.
3. Overflow (DEPTH=2): fill ch2 with 1, 2, then push 3 with rd_en=0 → 3 dropped, ovf[2]=1, head still 1. Pop ×2 yields 1, 2; ovf stays 1.
4. Push+pop when full: ch3 full (5, 6); same edge push 7 and pop → ovf[3]=0, occ3=2, drain order 6, 7, one credit pulse.
5. Flush: ch0 holds 2 entries, ovf[0]=1; assert conf_en one cycle with d_in valid → occ0=0, d_out valid=0, ovf[0]=0, no c_out pulse, d_in word not stored.
6. Pop empty and async reset mid-operation:
   - rd_en on empty ch1 → no c_out.
   - With entries queued, drop rst between edges → all outputs 0 immediately, without waiting for a clock edge.
